// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request at a time,
// presents fetched words to decode and applies branch/jump redirects, squashing stale fetches.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_base,
  input  logic [31:0] redirect_imm,
  input  logic        redirect_jalr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  output logic        misalign_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] pend_pc;
  logic        pend;
  logic        kill;
  logic [31:0] target;
  logic        legal;

  always_comb begin
    target = redirect_base + redirect_imm;
    if (redirect_jalr) target[0] = 1'b0;
  end

  assign legal = redirect & ~target[1];

  // Later assignments in a state branch deliberately override the generic pend capture,
  // so a redirect consumed in the same cycle never leaves a stale pending target behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      fetch_pc       <= RESET_PC;
      pend_pc        <= RESET_PC;
      pend           <= 1'b0;
      kill           <= 1'b0;
      imem_req       <= 1'b0;
      imem_addr      <= RESET_PC;
      instr_valid    <= 1'b0;
      instr          <= NOP_INSTR;
      instr_pc       <= RESET_PC;
      instr_pc_plus4 <= RESET_PC + 32'd4;
      misalign_err   <= 1'b0;
    end else begin
      misalign_err <= redirect & target[1];
      if (legal) begin
        pend_pc <= target;
        pend    <= 1'b1;
      end
      case (state)
        IDLE: begin
          state     <= REQ;
          imem_req  <= 1'b1;
          imem_addr <= fetch_pc;
        end
        REQ: begin
          if (imem_gnt) begin
            state    <= WAIT;
            imem_req <= 1'b0;
            kill     <= pend | legal;
          end
        end
        WAIT: begin
          if (legal) kill <= 1'b1;
          if (imem_rvalid) begin
            if (kill | legal) begin
              fetch_pc  <= legal ? target : pend_pc;
              imem_addr <= legal ? target : pend_pc;
              imem_req  <= 1'b1;
              pend      <= 1'b0;
              kill      <= 1'b0;
              state     <= REQ;
            end else begin
              instr          <= imem_rdata;
              instr_pc       <= fetch_pc;
              instr_pc_plus4 <= fetch_pc + 32'd4;
              instr_valid    <= 1'b1;
              state          <= HOLD;
            end
          end
        end
        HOLD: begin
          if (legal) begin
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            fetch_pc    <= target;
            imem_addr   <= target;
            imem_req    <= 1'b1;
            pend        <= 1'b0;
            state       <= REQ;
          end else if (instr_ready & ~redirect) begin
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            fetch_pc    <= fetch_pc + 32'd4;
            imem_addr   <= fetch_pc + 32'd4;
            imem_req    <= 1'b1;
            state       <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against
// an architectural next-PC model fed by a single-outstanding memory responder.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_base = 32'h0;
  logic [31:0] redirect_imm = 32'h0;
  logic        redirect_jalr = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        misalign_err;

  int checks = 0;
  int passed = 0;

  bit          gnt_low = 1'b0;
  bit          gnt_rand = 1'b0;
  bit          rand_delay = 1'b0;
  int          fixed_delay = 1;
  bit          force_en = 1'b0;
  logic [31:0] force_data = 32'h0;

  int          resp_cnt = 0;
  logic [31:0] resp_data = 32'h0;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_base(redirect_base), .redirect_imm(redirect_imm),
    .redirect_jalr(redirect_jalr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Instruction memory: decides gnt/rvalid at the falling edge, one response in flight.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (resp_cnt != 0) begin
      resp_cnt = resp_cnt - 1;
      if (resp_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = resp_data;
      end
    end
    if (gnt_low || resp_cnt != 0) imem_gnt = 1'b0;
    else if (gnt_rand)            imem_gnt = ($urandom_range(0, 1) == 1);
    else                          imem_gnt = 1'b1;
    if (imem_gnt && imem_req) begin
      resp_cnt  = rand_delay ? $urandom_range(1, 3) : fixed_delay;
      resp_data = force_en ? force_data : mem_word(imem_addr);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect = 1'b0;
    instr_ready = 1'b0;
    repeat (6) step();
    reset = 1'b0;
  endtask

  task automatic wait_until(input int kind, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if ((kind == 0 && instr_valid) || (kind == 1 && imem_req) ||
          (kind == 2 && imem_req && imem_gnt)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic drive_redirect(input logic [31:0] base, input logic [31:0] imm, input logic jalr);
    redirect = 1'b1;
    redirect_base = base;
    redirect_imm = imm;
    redirect_jalr = jalr;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++; if (imem_req !== 1'b0) $display("[TB] FAIL reset_req: got %b expected 0", imem_req); else passed++;
    checks++; if (imem_addr !== RESET_PC) $display("[TB] FAIL reset_addr: got %h expected %h", imem_addr, RESET_PC); else passed++;
    checks++; if (instr_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); else passed++;
    checks++; if (instr !== NOP_INSTR) $display("[TB] FAIL reset_instr: got %h expected %h", instr, NOP_INSTR); else passed++;
    checks++; if (instr_pc !== RESET_PC) $display("[TB] FAIL reset_pc: got %h expected %h", instr_pc, RESET_PC); else passed++;
    checks++; if (instr_pc_plus4 !== RESET_PC + 32'd4) $display("[TB] FAIL reset_pc4: got %h expected %h", instr_pc_plus4, RESET_PC + 32'd4); else passed++;
    checks++; if (misalign_err !== 1'b0) $display("[TB] FAIL reset_misalign: got %b expected 0", misalign_err); else passed++;
  endtask

  task automatic test_first_fetch();
    bit ok;
    gnt_low = 0; gnt_rand = 0; rand_delay = 0; fixed_delay = 1; force_en = 0;
    do_reset();
    instr_ready = 1'b1;
    wait_until(1, 20, ok);
    checks++; if (!ok || imem_addr !== 32'h0) $display("[TB] FAIL first_addr: got %h ok=%b expected 00000000", imem_addr, ok); else passed++;
    wait_until(0, 20, ok);
    checks++; if (!ok || instr !== 32'h0050_0093) $display("[TB] FAIL first_instr: got %h ok=%b expected 00500093", instr, ok); else passed++;
    checks++; if (instr_pc !== 32'h0 || instr_pc_plus4 !== 32'h4) $display("[TB] FAIL first_pc: got %h/%h expected 00000000/00000004", instr_pc, instr_pc_plus4); else passed++;
    step();
    wait_until(1, 20, ok);
    checks++; if (!ok || imem_addr !== 32'h4) $display("[TB] FAIL second_addr: got %h ok=%b expected 00000004", imem_addr, ok); else passed++;
  endtask

  task automatic test_hold_redirect();
    bit ok;
    instr_ready = 1'b0;
    wait_until(0, 20, ok);
    checks++; if (!ok) $display("[TB] FAIL hold_reach: got no valid expected valid"); else passed++;
    drive_redirect(32'h100, 32'hFFFF_FFF0, 1'b0);
    instr_ready = 1'b1;
    step();
    redirect = 1'b0;
    instr_ready = 1'b0;
    checks++; if (instr_valid !== 1'b0 || instr !== NOP_INSTR) $display("[TB] FAIL hold_squash: got valid=%b instr=%h expected 0/%h", instr_valid, instr, NOP_INSTR); else passed++;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hF0) $display("[TB] FAIL hold_target: got req=%b addr=%h expected 1/000000f0", imem_req, imem_addr); else passed++;
    wait_until(0, 20, ok);
    checks++; if (!ok || instr_pc !== 32'hF0 || instr !== mem_word(32'hF0)) $display("[TB] FAIL hold_next: got pc=%h instr=%h expected 000000f0/%h", instr_pc, instr, mem_word(32'hF0)); else passed++;
  endtask

  task automatic test_wait_redirect();
    bit ok;
    bit saw_valid;
    instr_ready = 1'b1;
    fixed_delay = 2;
    force_en = 1'b1;
    force_data = 32'hDEAD_BEEF;
    wait_until(2, 40, ok);
    checks++; if (!ok) $display("[TB] FAIL wait_grant: got no grant expected grant"); else passed++;
    step();
    force_en = 1'b0;
    drive_redirect(32'h20, 32'h40, 1'b0);
    step();
    redirect = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (instr_valid) saw_valid = 1'b1;
      if (imem_req) break;
      step();
    end
    checks++; if (saw_valid) $display("[TB] FAIL wait_discard: got valid=1 expected 0"); else passed++;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h60) $display("[TB] FAIL wait_target: got req=%b addr=%h expected 1/00000060", imem_req, imem_addr); else passed++;
    fixed_delay = 1;
    instr_ready = 1'b0;
    wait_until(0, 20, ok);
    checks++; if (!ok || instr_pc !== 32'h60 || instr !== mem_word(32'h60)) $display("[TB] FAIL wait_next: got pc=%h instr=%h expected 00000060/%h", instr_pc, instr, mem_word(32'h60)); else passed++;
  endtask

  task automatic test_gnt_stall();
    bit ok;
    bit saw_valid;
    logic [31:0] a;
    instr_ready = 1'b1;
    gnt_low = 1'b1;
    wait_until(1, 40, ok);
    checks++; if (!ok) $display("[TB] FAIL stall_req: got no request expected request"); else passed++;
    a = imem_addr;
    for (int i = 0; i < 5; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== a) $display("[TB] FAIL stall_stable: got req=%b addr=%h expected 1/%h", imem_req, imem_addr, a); else passed++;
      if (i == 1)      drive_redirect(32'h200, 32'h0, 1'b0);
      else if (i == 3) drive_redirect(32'h300, 32'h0, 1'b0);
      else             redirect = 1'b0;
      step();
    end
    redirect = 1'b0;
    gnt_low = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== a) $display("[TB] FAIL stall_hold: got req=%b addr=%h expected 1/%h", imem_req, imem_addr, a); else passed++;
    wait_until(2, 10, ok);
    step();
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (instr_valid) saw_valid = 1'b1;
      if (imem_req) break;
      step();
    end
    checks++; if (!ok || saw_valid) $display("[TB] FAIL stall_kill: got ok=%b valid_seen=%b expected 1/0", ok, saw_valid); else passed++;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) $display("[TB] FAIL stall_target: got req=%b addr=%h expected 1/00000300", imem_req, imem_addr); else passed++;
  endtask

  task automatic test_misalign();
    bit ok;
    logic [31:0] p;
    instr_ready = 1'b0;
    wait_until(0, 20, ok);
    p = instr_pc;
    drive_redirect(32'h1001, 32'h2, 1'b1);
    step();
    redirect = 1'b0;
    checks++; if (misalign_err !== 1'b1) $display("[TB] FAIL mis_pulse: got %b expected 1", misalign_err); else passed++;
    checks++; if (!ok || instr_valid !== 1'b1 || instr_pc !== p) $display("[TB] FAIL mis_keep: got valid=%b pc=%h expected 1/%h", instr_valid, instr_pc, p); else passed++;
    step();
    checks++; if (misalign_err !== 1'b0) $display("[TB] FAIL mis_end: got %b expected 0", misalign_err); else passed++;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== p + 32'd4) $display("[TB] FAIL mis_seq: got req=%b addr=%h expected 1/%h", imem_req, imem_addr, p + 32'd4); else passed++;
  endtask

  task automatic test_wrap_and_reset();
    bit ok;
    instr_ready = 1'b0;
    wait_until(0, 20, ok);
    drive_redirect(32'hFFFF_FFF0, 32'hC, 1'b0);
    step();
    redirect = 1'b0;
    wait_until(0, 20, ok);
    checks++; if (!ok || instr_pc !== 32'hFFFF_FFFC || instr_pc_plus4 !== 32'h0) $display("[TB] FAIL wrap_pc: got %h/%h expected fffffffc/00000000", instr_pc, instr_pc_plus4); else passed++;
    checks++; if (instr !== mem_word(32'hFFFF_FFFC)) $display("[TB] FAIL wrap_instr: got %h expected %h", instr, mem_word(32'hFFFF_FFFC)); else passed++;
    fixed_delay = 3;
    force_en = 1'b1;
    force_data = 32'hDEAD_BEEF;
    instr_ready = 1'b1;
    wait_until(2, 20, ok);
    checks++; if (!ok || imem_addr !== 32'h0) $display("[TB] FAIL wrap_next: got addr=%h ok=%b expected 00000000", imem_addr, ok); else passed++;
    step();
    force_en = 1'b0;
    fixed_delay = 1;
    reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== RESET_PC) $display("[TB] FAIL midreset: got req=%b valid=%b addr=%h expected 0/0/%h", imem_req, instr_valid, imem_addr, RESET_PC); else passed++;
    step();
    reset = 1'b0;
    wait_until(1, 20, ok);
    checks++; if (!ok || imem_addr !== RESET_PC) $display("[TB] FAIL restart_addr: got %h ok=%b expected %h", imem_addr, ok, RESET_PC); else passed++;
    wait_until(0, 20, ok);
    checks++; if (!ok || instr_pc !== RESET_PC || instr !== mem_word(RESET_PC)) $display("[TB] FAIL stale_ignored: got pc=%h instr=%h expected %h/%h", instr_pc, instr, RESET_PC, mem_word(RESET_PC)); else passed++;
    instr_ready = 1'b0;
  endtask

  // Architectural model: the next presented instruction is at exp_pc, which moves to the
  // latest legal redirect target or advances by 4 on each accepted transfer.
  task automatic test_random();
    logic [31:0] exp_pc, tgt, addr_prev, base, imm;
    bit exp_mis, req_prev, gnt_prev, jalr;
    int transfers;
    do_reset();
    gnt_rand = 1'b1;
    rand_delay = 1'b1;
    exp_pc = RESET_PC;
    exp_mis = 1'b0;
    req_prev = 1'b0;
    gnt_prev = 1'b0;
    addr_prev = 32'h0;
    transfers = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      step();
      checks++; if (misalign_err !== exp_mis) $display("[TB] FAIL rnd_misalign cyc %0d: got %b expected %b", cyc, misalign_err, exp_mis); else passed++;
      if (instr_valid) begin
        checks++; if (instr_pc !== exp_pc || instr_pc_plus4 !== exp_pc + 32'd4) $display("[TB] FAIL rnd_pc cyc %0d: got %h/%h expected %h/%h", cyc, instr_pc, instr_pc_plus4, exp_pc, exp_pc + 32'd4); else passed++;
        checks++; if (instr !== mem_word(exp_pc)) $display("[TB] FAIL rnd_instr cyc %0d: got %h expected %h", cyc, instr, mem_word(exp_pc)); else passed++;
      end else begin
        checks++; if (instr !== NOP_INSTR) $display("[TB] FAIL rnd_nop cyc %0d: got %h expected %h", cyc, instr, NOP_INSTR); else passed++;
      end
      if (req_prev && !gnt_prev) begin
        checks++; if (imem_req !== 1'b1 || imem_addr !== addr_prev) $display("[TB] FAIL rnd_req_stable cyc %0d: got req=%b addr=%h expected 1/%h", cyc, imem_req, imem_addr, addr_prev); else passed++;
      end
      if (imem_req) begin
        checks++; if (imem_addr[1:0] !== 2'b00) $display("[TB] FAIL rnd_align cyc %0d: got %h expected word aligned", cyc, imem_addr); else passed++;
      end
      instr_ready = ($urandom_range(0, 9) < 7);
      redirect = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        base = $urandom;
        imm = $urandom;
        imm = {{20{imm[11]}}, imm[11:0]};
        jalr = ($urandom_range(0, 1) == 1);
        if (!jalr) begin
          base[0] = 1'b0;
          imm[0] = 1'b0;
        end
        tgt = base + imm;
        if (jalr) tgt[0] = 1'b0;
        if (tgt[1] && $urandom_range(0, 3) != 0) imm = imm + 32'd2;
        drive_redirect(base, imm, jalr);
      end
      tgt = redirect_base + redirect_imm;
      if (redirect_jalr) tgt[0] = 1'b0;
      exp_mis = redirect && tgt[1];
      if (redirect && !tgt[1]) exp_pc = tgt;
      else if (!redirect && instr_valid && instr_ready) begin
        exp_pc = exp_pc + 32'd4;
        transfers++;
      end
      req_prev = imem_req;
      gnt_prev = imem_gnt;
      addr_prev = imem_addr;
    end
    redirect = 1'b0;
    checks++; if (transfers < 50) $display("[TB] FAIL rnd_progress: got %0d transfers expected at least 50", transfers); else passed++;
    gnt_rand = 1'b0;
    rand_delay = 1'b0;
  endtask

  initial begin
    $display("[TB] fetch_unit bench start");
    test_reset();
    test_first_fetch();
    test_hold_redirect();
    test_wait_redirect();
    test_gnt_stall();
    test_misalign();
    test_wrap_and_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
